// File: rtl/modp_square_root.sv
// Modular square root r = a_squared^((P+1)/4) mod P for a prime P = 3 mod 4.
// A single bit-serial modular multiplier runs every square and multiply, so latency is data-independent.
module modp_square_root #(
    parameter int             W = 256,
    parameter logic [W-1:0]   P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] a_squared,
    output logic [W-1:0] out,
    output logic         Done
);

    localparam int           CW      = $clog2(W);
    localparam logic [W:0]   P_EXT   = {1'b0, P};
    // (P+1)/4 without overflowing W bits, valid because P = 3 mod 4
    localparam logic [W-1:0] E       = (P >> 2) + W'(1);
    localparam logic [CW-1:0] BIT_TOP = CW'(W - 1);
    localparam logic [CW-1:0] EXP_TOP = CW'(W - 3);

    typedef enum logic [1:0] {IDLE, EXP, FINAL, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic          load_en;
    logic          step_en;
    logic          final_en;

    logic [W-1:0]  acc;
    logic [W-1:0]  r;
    logic [W-1:0]  base;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          phase;

    logic [W-1:0]  op1;
    logic [W-1:0]  addend;
    logic [W-1:0]  acc_dbl;
    logic [W-1:0]  next_acc;
    logic [W-1:0]  base_red;
    logic [W-1:0]  root_neg;
    logic          unused_a;

    assign unused_a = ^a[W-1:1];

    // Inputs are below 2P, so one conditional subtraction fully reduces them
    function automatic logic [W-1:0] mod_reduce(input logic [W:0] x);
        return (x >= P_EXT) ? W'(x - P_EXT) : W'(x);
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = EXP;
            EXP:   if (cnt == '0 && phase && idx == '0) next_state = FINAL;
            FINAL: next_state = DONE;
            DONE:  next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // IDLE lasts exactly one edge after release; that edge performs the load
    always_comb begin
        load_en  = (state == IDLE);
        step_en  = (state == EXP);
        final_en = (state == FINAL);
        Done     = (state == DONE);
    end

    always_comb begin
        op1      = phase ? (E[idx] ? base : W'(1)) : r;
        addend   = r[cnt] ? op1 : '0;
        acc_dbl  = mod_reduce({acc, 1'b0});
        next_acc = mod_reduce({1'b0, acc_dbl} + {1'b0, addend});
        base_red = (a_squared >= P) ? a_squared - P : a_squared;
        root_neg = (r == '0) ? '0 : P - r;
    end

    // r is the multiplier's first operand and is only overwritten when a product completes
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc   <= '0;
            r     <= '0;
            base  <= '0;
            cnt   <= '0;
            idx   <= '0;
            phase <= 1'b0;
            out   <= '0;
        end else if (load_en) begin
            base  <= base_red;
            r     <= W'(1);
            acc   <= '0;
            cnt   <= BIT_TOP;
            idx   <= EXP_TOP;
            phase <= 1'b0;
        end else if (step_en) begin
            if (cnt == '0) begin
                r     <= next_acc;
                acc   <= '0;
                cnt   <= BIT_TOP;
                phase <= ~phase;
                if (phase) idx <= idx - 1'b1;
            end else begin
                acc <= next_acc;
                cnt <= cnt - 1'b1;
            end
        end else if (final_en) begin
            out <= (r[0] == a[0]) ? r : root_neg;
        end
    end

endmodule

// File: tb/tb_modp_square_root.sv
// Bench for modp_square_root, run on the 16-bit prime 65519 (= 3 mod 4) so each root takes 450 cycles.
module tb_modp_square_root;

    localparam int           W   = 16;
    localparam logic [W-1:0] P   = 16'hFFEF;
    localparam longint       PL  = 65519;
    localparam int           LAT = 2 * (W - 2) * W + 2;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [W-1:0] a;
    logic [W-1:0] a_squared;
    logic [W-1:0] out;
    logic         Done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [W-1:0] a_v;
        logic [W-1:0] asq_v;
        logic [W-1:0] exp_v;
        bit           is_res;
    } vec_t;

    vec_t vecs[14];

    always #5 Clk = ~Clk;

    modp_square_root #(.W(W), .P(P)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .a         (a),
        .a_squared (a_squared),
        .out       (out),
        .Done      (Done)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a_v, input logic [W-1:0] asq_v, output int edges);
        Reset     = 1'b0;
        a         = a_v;
        a_squared = asq_v;
        @(negedge Clk);
        Reset = 1'b1;
        edges = 0;
        while (Done !== 1'b1 && edges < LAT + 20) begin
            @(posedge Clk);
            #1;
            edges++;
        end
    endtask

    task automatic runVector(input string name, input logic [W-1:0] a_v, input logic [W-1:0] asq_v,
                             input logic [W-1:0] exp_v, input bit is_res);
        int edges;
        applyStimulus(a_v, asq_v, edges);
        checkOutput({name, "_done"}, longint'(Done), 1);
        checkOutput({name, "_latency"}, edges, LAT);
        checkOutput({name, "_out"}, longint'(out), longint'(exp_v));
        if (is_res)
            checkOutput({name, "_square"}, (longint'(out) * longint'(out)) % PL, longint'(asq_v) % PL);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           edges;
        int           x;
        int           held;
        logic [W-1:0] a_r;
        logic [W-1:0] xv;

        vecs[0]  = '{"sqrt100_even",  16'd10, 16'd100,   16'd10,    1'b1};
        vecs[1]  = '{"sqrt100_odd",   16'd11, 16'd100,   16'd65509, 1'b1};
        vecs[2]  = '{"sqrt4_odd",     16'd1,  16'd4,     16'd65517, 1'b1};
        vecs[3]  = '{"sqrt4_even",    16'd0,  16'd4,     16'd2,     1'b1};
        vecs[4]  = '{"unreduced_p4",  16'd0,  16'd65523, 16'd2,     1'b1};
        vecs[5]  = '{"zero_even",     16'd0,  16'd0,     16'd0,     1'b1};
        vecs[6]  = '{"zero_odd",      16'd1,  16'd0,     16'd0,     1'b1};
        vecs[7]  = '{"eqp_even",      16'd0,  16'd65519, 16'd0,     1'b1};
        vecs[8]  = '{"eqp_odd",       16'd1,  16'd65519, 16'd0,     1'b1};
        vecs[9]  = '{"max_input",     16'd0,  16'd65535, 16'd4,     1'b1};
        vecs[10] = '{"nonres_odd",    16'd1,  16'd65518, 16'd1,     1'b0};
        vecs[11] = '{"nonres_even",   16'd0,  16'd65518, 16'd65518, 1'b0};
        vecs[12] = '{"sqrt9_odd",     16'd1,  16'd9,     16'd3,     1'b1};
        vecs[13] = '{"sqrt25_high_a", 16'hFF05, 16'd25,  16'd5,     1'b1};

        Reset     = 1'b0;
        a         = '0;
        a_squared = '0;
        #2;
        checkOutput("reset_done", longint'(Done), 0);
        checkOutput("reset_out", longint'(out), 0);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_held_done", longint'(Done), 0);

        for (int i = 0; i < 14; i++)
            runVector(vecs[i].name, vecs[i].a_v, vecs[i].asq_v, vecs[i].exp_v, vecs[i].is_res);

        // Done and out must hold after completion
        held = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk);
            #1;
            if (Done !== 1'b1 || out !== 16'd5) held = 0;
        end
        checkOutput("hold_100_cycles", held, 1);

        // Asynchronous clear with no clock edge involved
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        checkOutput("async_clear_done", longint'(Done), 0);
        checkOutput("async_clear_out", longint'(out), 0);

        // Abort mid-computation, then a fresh run from the second release
        a         = 16'd10;
        a_squared = 16'd100;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (200) @(posedge Clk);
        #1;
        checkOutput("midop_busy", longint'(Done), 0);
        Reset = 1'b0;
        #1;
        checkOutput("midop_abort_done", longint'(Done), 0);
        checkOutput("midop_abort_out", longint'(out), 0);
        applyStimulus(16'd1, 16'd9, edges);
        checkOutput("restart_done", longint'(Done), 1);
        checkOutput("restart_latency", edges, LAT);
        checkOutput("restart_out", longint'(out), 3);

        for (int k = 0; k < 4; k++) begin
            x   = $urandom_range(1, 65518);
            xv  = W'(x);
            a_r = W'($urandom);
            runVector($sformatf("random%0d", k), a_r, W'((longint'(x) * longint'(x)) % PL),
                      (xv[0] == a_r[0]) ? xv : W'(PL - longint'(x)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modp_square_root.md
Name: modp_square_root

Overview:
- Computes the modular square root of a 256-bit field element modulo a prime P, where P ≡ 3 (mod 4). It uses r = a_squared^((P+1)/4) mod P.
- Used as the point-decompression helper in the elliptic-curve datapath.
- Input `a` supplies the required root parity: out is the root whose LSB equals a[0].
- Constant-time: one multi-cycle modular multiplier is reused for every square and multiply step.

Parameters:
- P, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F (secp256k1 prime); field modulus, must satisfy P mod 4 = 3.

Ports:
- Clk  input  1  single system clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset. Low clears all state; a rising edge of Reset (release) starts a computation.
- a  input  256  parity selector; only a[0] is used. Must be stable from release of Reset until Done.
- a_squared  input  256  radicand; may be any value in 0..2^256-1. Must be stable from release of Reset until Done.
- out  output  256  square root result, in range 0..P-1.
- Done  output  1  result valid; held high until the next reset.

Behaviour:
- Reset low (async): out=0, Done=0, counter=0, accumulator=0, internal state=IDLE.
- States:
  - IDLE: entered from reset.
  - LOAD: one cycle. On the first rising Clk edge after Reset goes high, the block computes base = a_squared mod P (a single conditional subtraction of P suffices since 2P > 2^256) and sets accumulator R = 1.
  - EXP: for exponent bits e[253] down to e[0] of E=(P+1)/4, two products per bit:
    - R = R·R mod P.
    - R = R·(e[i] ? base : 1) mod P. The multiply is always performed (constant time).
  - FINAL: one cycle.
    - If R[0] == a[0], out = R; otherwise out = (R==0) ? 0 : P−R.
    - Done = 1.
  - DONE: holds out and Done until reset.
- Modular multiplier:
  - Interleaved MSB-first shift-add on operands op0_in, op1_in; one operand bit per cycle, exactly 256 cycles per product.
  - Each cycle: acc = 2·acc mod P, then acc = acc + (bit ? op1 : 0) mod P. Each step is reduced by at most one conditional subtraction of P.
  - Internal width 257 bits to hold intermediate sums before reduction.
- Counter: 8-bit counter tracks multiplier bit position (255→0); a separate index tracks exponent bit (253→0).
- Latency: LOAD 1 + 508 products × 256 + FINAL 1 = Done rises on the 130050th rising Clk edge after Reset release. It is identical for every input.
- Non-residue: no check is made. out = parity-adjusted a_squared^E mod P, and Done asserts as normal.
- a_squared = 0 or P gives out = 0 regardless of a[0].
- Reset asserted mid-operation: immediate abort; out=0, Done=0. A fresh computation starts on the next release.
- Input changes during computation: not supported. The block uses the base latched at LOAD and samples a[0] in FINAL.
- Done never pulses low once set except via reset.

Test Plan:
- Reset low→high, a=10, a_squared=100 → after exactly 130050 edges Done=1, out=10 (10 is even; matches a[0]=0).
- a=11, a_squared=100 → out = P−10 = 0xFFFF…FFFEFFFFFC25; Done=1 at the same cycle count.
- a=1, a_squared=4 → out = P−2; a=0, a_squared=4 → out=2; verify out² mod P == a_squared in both cases.
- a_squared = P+4 (unreduced input), a=0 → out=2; a_squared=0 and a_squared=P → out=0 for both a[0] values.
- Reset pulsed low at edge 60000, then released with a_squared=9, a=1 → Done/out clear asynchronously. Done rises 130050 edges after the second release with out=3.
- Random residues (x² mod P for random x) → out ∈ {x, P−x} with LSB = a[0]; Done stays high over 100 extra cycles and out holds.
